router_xy_route_compute: RTL and testbench

- Route-computation stage of the router_wrap slice; directly consumes the registered node coordinates (my_xpos, my_ypos) produced by the slice's MY_XPOS/MY_YPOS flip-flops.
- Accepts flits from the input buffer and applies dimension-ordered XY routing to each head flit.
- Locks the resulting output-port choice for the whole packet and presents flits plus a one-hot port select to the switch allocator through a one-stage registered valid/ready pipeline.

---
 rtl/router_xy_route_compute.sv | 150 +++++++++++++++
 tb/tb_router_xy_route_compute.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_xy_route_compute.sv
// XY route-computation stage: routes each head flit by dimension order, locks the
// port for the rest of the packet, and forwards flits through one registered stage.
module router_xy_route_compute #(
   parameter int unsigned COORD_W = 4,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [COORD_W-1:0] my_xpos,
   input  logic [COORD_W-1:0] my_ypos,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_flit,
   input  logic               in_head,
   input  logic               in_tail,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_flit,
   output logic               out_head,
   output logic               out_tail,
   output logic [4:0]         out_port,
   output logic               err_pulse,
   output logic [CNT_W-1:0]   pkt_count
);

   localparam int unsigned PORT_W = 5;
   localparam logic [PORT_W-1:0] PORT_E     = PORT_W'(5'b00001);
   localparam logic [PORT_W-1:0] PORT_W_DIR = PORT_W'(5'b00010);
   localparam logic [PORT_W-1:0] PORT_N     = PORT_W'(5'b00100);
   localparam logic [PORT_W-1:0] PORT_S     = PORT_W'(5'b01000);
   localparam logic [PORT_W-1:0] PORT_L     = PORT_W'(5'b10000);
   localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

   typedef enum logic {
      IDLE   = 1'b0,
      PACKET = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [PORT_W-1:0]   route_q, route_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_flit_q, out_flit_d;
   logic                out_head_q, out_head_d;
   logic                out_tail_q, out_tail_d;
   logic [PORT_W-1:0]   out_port_q, out_port_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                xfer;
   logic [COORD_W-1:0]  dest_x;
   logic [COORD_W-1:0]  dest_y;
   logic [PORT_W-1:0]   head_route;

   // X is resolved fully before Y, which keeps the mesh deadlock-free.
   function automatic logic [PORT_W-1:0] xy_route(
      input logic [COORD_W-1:0] dx,
      input logic [COORD_W-1:0] dy,
      input logic [COORD_W-1:0] mx,
      input logic [COORD_W-1:0] my
   );
      if (dx > mx)      return PORT_E;
      else if (dx < mx) return PORT_W_DIR;
      else if (dy > my) return PORT_N;
      else if (dy < my) return PORT_S;
      else              return PORT_L;
   endfunction

   assign in_ready   = !out_valid_q || out_ready;
   assign xfer       = in_valid && in_ready;
   assign dest_x     = in_flit[COORD_W-1:0];
   assign dest_y     = in_flit[2*COORD_W-1:COORD_W];
   assign head_route = xy_route(dest_x, dest_y, my_xpos, my_ypos);

   // Next-state and output-register logic.
   always_comb begin
      state_d     = state_q;
      route_d     = route_q;
      out_valid_d = out_valid_q;
      out_flit_d  = out_flit_q;
      out_head_d  = out_head_q;
      out_tail_d  = out_tail_q;
      out_port_d  = out_port_q;
      err_d       = 1'b0;
      cnt_d       = cnt_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (xfer) begin
         if (in_head) begin
            err_d       = (state_q == PACKET);
            route_d     = head_route;
            out_valid_d = 1'b1;
            out_flit_d  = in_flit;
            out_head_d  = 1'b1;
            out_tail_d  = in_tail;
            out_port_d  = head_route;
            cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            state_d     = in_tail ? IDLE : PACKET;
         end else if (state_q == PACKET) begin
            out_valid_d = 1'b1;
            out_flit_d  = in_flit;
            out_head_d  = 1'b0;
            out_tail_d  = in_tail;
            out_port_d  = route_q;
            if (in_tail) begin
               state_d = IDLE;
            end
         end else begin
            // Orphan body/tail flit: swallow it and flag the protocol error.
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         route_q     <= '0;
         out_valid_q <= 1'b0;
         out_flit_q  <= '0;
         out_head_q  <= 1'b0;
         out_tail_q  <= 1'b0;
         out_port_q  <= '0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         route_q     <= route_d;
         out_valid_q <= out_valid_d;
         out_flit_q  <= out_flit_d;
         out_head_q  <= out_head_d;
         out_tail_q  <= out_tail_d;
         out_port_q  <= out_port_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_flit  = out_flit_q;
   assign out_head  = out_head_q;
   assign out_tail  = out_tail_q;
   assign out_port  = out_port_q;
   assign err_pulse = err_q;
   assign pkt_count = cnt_q;

endmodule

// File: tb/tb_router_xy_route_compute.sv
// Directed bench for router_xy_route_compute: routing, packet locking, backpressure,
// protocol errors, asynchronous reset and counter saturation.
module tb_router_xy_route_compute;

   logic        clk;
   logic        reset;
   logic [3:0]  my_xpos, my_ypos;
   logic        in_valid, in_ready, in_head, in_tail;
   logic [31:0] in_flit;
   logic        out_valid, out_ready, out_head, out_tail, err_pulse;
   logic [31:0] out_flit;
   logic [4:0]  out_port;
   logic [15:0] pkt_count;

   // Narrow-counter instance so saturation is reachable in a few cycles.
   logic        s_in_valid, s_in_ready, s_in_head, s_in_tail;
   logic [31:0] s_in_flit;
   logic        s_out_valid, s_out_ready, s_out_head, s_out_tail, s_err_pulse;
   logic [31:0] s_out_flit;
   logic [4:0]  s_out_port;
   logic [2:0]  s_pkt_count;

   int n_tests = 0;
   int n_fail  = 0;

   router_xy_route_compute dut (
      .clk(clk), .reset(reset), .my_xpos(my_xpos), .my_ypos(my_ypos),
      .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
      .in_head(in_head), .in_tail(in_tail), .out_valid(out_valid),
      .out_ready(out_ready), .out_flit(out_flit), .out_head(out_head),
      .out_tail(out_tail), .out_port(out_port), .err_pulse(err_pulse),
      .pkt_count(pkt_count)
   );

   router_xy_route_compute #(.COORD_W(4), .DATA_W(32), .CNT_W(3)) u_sat (
      .clk(clk), .reset(reset), .my_xpos(my_xpos), .my_ypos(my_ypos),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_flit(s_in_flit),
      .in_head(s_in_head), .in_tail(s_in_tail), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .out_flit(s_out_flit), .out_head(s_out_head),
      .out_tail(s_out_tail), .out_port(s_out_port), .err_pulse(s_err_pulse),
      .pkt_count(s_pkt_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mk(input logic [3:0] x, input logic [3:0] y,
                                      input logic [23:0] tag);
      return {tag, y, x};
   endfunction

   task automatic test_reset();
      #2;
      n_tests++;
      if ({out_valid, out_flit, out_head, out_tail, out_port, err_pulse, pkt_count} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got v=%b f=%h p=%b e=%b c=%0d want all zero",
                  out_valid, out_flit, out_port, err_pulse, pkt_count);
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
      @(negedge clk) reset = 1'b1;
   endtask

   task automatic test_single();
      @(negedge clk);
      my_xpos = 4'd2; my_ypos = 4'd2; out_ready = 1'b1;
      in_valid = 1'b1; in_flit = mk(4'd5, 4'd1, 24'h000001); in_head = 1'b1; in_tail = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_tests++;
      if ({out_valid, out_head, out_tail, out_port} !== {3'b111, 5'b00001}) begin
         n_fail++;
         $display("FAIL single_route got v=%b h=%b t=%b p=%b want 1 1 1 00001",
                  out_valid, out_head, out_tail, out_port);
      end
      n_tests++;
      if (out_flit !== 32'h0000_0115) begin
         n_fail++; $display("FAIL single_flit got %h want 00000115", out_flit);
      end
      n_tests++;
      if (pkt_count !== 16'd1) begin
         n_fail++; $display("FAIL single_count got %0d want 1", pkt_count);
      end
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_drain got %b want 0", out_valid);
      end
   endtask

   task automatic test_packet();
      logic [31:0] f [4];
      f[0] = mk(4'd2, 4'd0, 24'h0000A0);
      f[1] = 32'hB0D1_0077;
      f[2] = 32'hB0D2_00F3;
      f[3] = 32'hB0D3_0021;
      @(negedge clk);
      in_valid = 1'b1; in_flit = f[0]; in_head = 1'b1; in_tail = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         n_tests++;
         if ({out_valid, out_port, out_flit, out_head, out_tail} !==
             {1'b1, 5'b01000, f[i-1], (i == 1), (i == 4)}) begin
            n_fail++;
            $display("FAIL packet_flit%0d got v=%b p=%b f=%h h=%b t=%b want p=01000 f=%h",
                     i-1, out_valid, out_port, out_flit, out_head, out_tail, f[i-1]);
         end
         if (i < 4) begin
            in_flit = f[i]; in_head = 1'b0; in_tail = (i == 3);
            if (i == 2) my_xpos = 4'd7;
         end else begin
            in_valid = 1'b0; my_xpos = 4'd2;
         end
      end
      n_tests++;
      if (pkt_count !== 16'd2) begin
         n_fail++; $display("FAIL packet_count got %0d want 2", pkt_count);
      end
      @(negedge clk);
   endtask

   task automatic test_routes();
      logic [3:0] dx [5] = '{4'd2, 4'd0, 4'd2, 4'd15, 4'd0};
      logic [3:0] dy [5] = '{4'd2, 4'd3, 4'd3, 4'd0,  4'd15};
      logic [3:0] mx [5] = '{4'd2, 4'd2, 4'd2, 4'd0,  4'd15};
      logic [3:0] my [5] = '{4'd2, 4'd2, 4'd2, 4'd15, 4'd0};
      logic [4:0] ep [5] = '{5'b10000, 5'b00010, 5'b00100, 5'b00001, 5'b00010};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i > 0) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_port !== ep[i-1]) begin
               n_fail++;
               $display("FAIL route_vec%0d got v=%b p=%b want 1 %b", i-1, out_valid, out_port, ep[i-1]);
            end
         end
         my_xpos = mx[i]; my_ypos = my[i];
         in_valid = 1'b1; in_flit = mk(dx[i], dy[i], 24'(i)); in_head = 1'b1; in_tail = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0; my_xpos = 4'd2; my_ypos = 4'd2;
      n_tests++;
      if (out_valid !== 1'b1 || out_port !== ep[4]) begin
         n_fail++; $display("FAIL route_vec4 got v=%b p=%b want 1 %b", out_valid, out_port, ep[4]);
      end
      n_tests++;
      if (pkt_count !== 16'd7) begin
         n_fail++; $display("FAIL route_count got %0d want 7", pkt_count);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [31:0] fa, fb, fc, fd;
      fa = mk(4'd2, 4'd2, 24'hAAAAAA); fb = mk(4'd2, 4'd2, 24'hBBBBBB);
      fc = mk(4'd2, 4'd2, 24'hCCCCCC); fd = mk(4'd2, 4'd2, 24'hDDDDDD);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; in_flit = fa; in_head = 1'b1; in_tail = 1'b1;
      @(negedge clk);
      in_flit = fb;
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_flit !== fa) begin
            n_fail++;
            $display("FAIL stall_cycle%0d got rdy=%b v=%b f=%h want 0 1 %h", i, in_ready, out_valid, out_flit, fa);
         end
         if (i < 4) @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (out_flit !== fb || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL stream_b got v=%b f=%h want 1 %h", out_valid, out_flit, fb);
      end
      in_flit = fc;
      @(negedge clk);
      n_tests++;
      if (out_flit !== fc || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL stream_c got v=%b f=%h want 1 %h", out_valid, out_flit, fc);
      end
      in_flit = fd;
      @(negedge clk);
      in_valid = 1'b0;
      n_tests++;
      if (out_flit !== fd || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL stream_d got v=%b f=%h want 1 %h", out_valid, out_flit, fd);
      end
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || pkt_count !== 16'd11) begin
         n_fail++; $display("FAIL stream_end got v=%b c=%0d want 0 11", out_valid, pkt_count);
      end
   endtask

   task automatic test_errors();
      @(negedge clk);
      in_valid = 1'b1; in_flit = 32'h0000_0033; in_head = 1'b0; in_tail = 1'b0;
      @(negedge clk);
      n_tests++;
      if (err_pulse !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL orphan_body got err=%b v=%b want 1 0", err_pulse, out_valid);
      end
      in_tail = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_tests++;
      if (err_pulse !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL orphan_tail got err=%b v=%b want 1 0", err_pulse, out_valid);
      end
      @(negedge clk);
      n_tests++;
      if (err_pulse !== 1'b0) begin
         n_fail++; $display("FAIL err_clear got %b want 0", err_pulse);
      end
      in_valid = 1'b1; in_flit = mk(4'd5, 4'd2, 24'h0000E1); in_head = 1'b1; in_tail = 1'b0;
      @(negedge clk);
      n_tests++;
      if (err_pulse !== 1'b0 || out_port !== 5'b00001) begin
         n_fail++; $display("FAIL head_open got err=%b p=%b want 0 00001", err_pulse, out_port);
      end
      in_flit = mk(4'd0, 4'd2, 24'h0000E2); in_tail = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({err_pulse, out_valid, out_head, out_port} !== {3'b111, 5'b00010}) begin
         n_fail++;
         $display("FAIL head_in_packet got err=%b v=%b h=%b p=%b want 1 1 1 00010",
                  err_pulse, out_valid, out_head, out_port);
      end
      in_flit = 32'h0000_0044; in_head = 1'b0; in_tail = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      n_tests++;
      if (err_pulse !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL body_after_ht got err=%b v=%b want 1 0", err_pulse, out_valid);
      end
      n_tests++;
      if (pkt_count !== 16'd13) begin
         n_fail++; $display("FAIL error_count got %0d want 13", pkt_count);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      in_valid = 1'b1; in_flit = mk(4'd5, 4'd1, 24'h0000F0); in_head = 1'b1; in_tail = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      n_tests++;
      if (out_valid !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset_valid got %b want 1", out_valid);
      end
      #2 reset = 1'b0;
      #1;
      n_tests++;
      if ({out_valid, out_flit, out_head, out_tail, out_port, pkt_count} !== '0) begin
         n_fail++;
         $display("FAIL async_reset got v=%b f=%h p=%b c=%0d want all zero",
                  out_valid, out_flit, out_port, pkt_count);
      end
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
      in_valid = 1'b1; in_flit = 32'h0000_0055; in_head = 1'b0; in_tail = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_tests++;
      if (err_pulse !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_body got err=%b v=%b want 1 0", err_pulse, out_valid);
      end
      @(negedge clk);
   endtask

   task automatic test_saturation();
      s_out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i == 7) begin
            n_tests++;
            if (s_pkt_count !== 3'd7) begin
               n_fail++; $display("FAIL sat_reach got %0d want 7", s_pkt_count);
            end
         end
         s_in_valid = 1'b1; s_in_flit = mk(4'd2, 4'd2, 24'(i)); s_in_head = 1'b1; s_in_tail = 1'b1;
      end
      @(negedge clk);
      s_in_valid = 1'b0;
      n_tests++;
      if (s_pkt_count !== 3'd7 || s_out_valid !== 1'b1) begin
         n_fail++; $display("FAIL sat_hold got c=%0d v=%b want 7 1", s_pkt_count, s_out_valid);
      end
   endtask

   initial begin
      reset = 1'b0;
      my_xpos = 4'd0; my_ypos = 4'd0;
      in_valid = 1'b0; in_flit = '0; in_head = 1'b0; in_tail = 1'b0; out_ready = 1'b0;
      s_in_valid = 1'b0; s_in_flit = '0; s_in_head = 1'b0; s_in_tail = 1'b0; s_out_ready = 1'b0;
      test_reset();
      test_single();
      test_packet();
      test_routes();
      test_back_to_back();
      test_errors();
      test_reset_mid();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
